oai221_sweep_checker: RTL
=========================

Name: oai221_sweep_checker

Overview:
- Stimulus/response harness that drives the five inputs of an OAI221 complex-gate instance and checks its ZN output against a truth table.
- It forms the driving end of the gate's interface: it sequences all 32 input vectors, waits a programmable settle time, samples ZN, and records mismatches.
- Used in the characterization/bring-up fabric next to standard-cell instances, and in the gate-level regression bench.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before ZN is sampled. Legal range 0..15.
- EXPECT, 32'h111F_FFFF, expected ZN per vector. Bit i is the value for vector index i. The default is the OAI221 function ZN = !(A & (B1|B2) & (C1|C2)).

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous active-high reset.
- START  input  1  begins a sweep. Sampled only in IDLE or DONE.
- ABORT  input  1  terminates a running sweep.
- ZN  input  1  output of the gate under test.
- A  output  1  stimulus, equals vector index bit 4.
- B1  output  1  stimulus, equals vector index bit 3.
- B2  output  1  stimulus, equals vector index bit 2.
- C1  output  1  stimulus, equals vector index bit 1.
- C2  output  1  stimulus, equals vector index bit 0.
- BUSY  output  1  sweep in progress.
- DONE  output  1  sweep completed; level, held until the next START or RST.
- PASS  output  1  DONE and zero mismatches.
- ERR_CNT  output  6  number of mismatching vectors in the current/last sweep (0..32).
- FAIL_VALID  output  1  at least one mismatch recorded.
- FIRST_FAIL  output  5  index of the first mismatching vector; valid when FAIL_VALID=1.

Behaviour:
- Reset (async, RST=1): state IDLE; idx=0; settle count=0. Outputs A, B1, B2, C1, C2, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID and FIRST_FAIL are all 0. Reset mid-sweep aborts immediately, with no completion indication.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE:
  - Stimulus outputs are 0.
  - START=1 at an edge: enter DRIVE; idx=0; cnt=0; clear ERR_CNT, FAIL_VALID and FIRST_FAIL; BUSY=1.
- DRIVE:
  - Stimulus outputs = idx[4:0], registered, so the new vector appears the cycle after idx changes.
  - At each edge with cnt<SETTLE_CYCLES: cnt++.
  - At the edge with cnt==SETTLE_CYCLES: compare ZN with EXPECT[idx].
  - On mismatch: ERR_CNT++. If FAIL_VALID=0, set FIRST_FAIL=idx and FAIL_VALID=1.
  - Then, if idx==31: enter DONE. Otherwise idx++ and cnt=0.
  - Each vector is held exactly SETTLE_CYCLES+1 cycles. A sweep lasts 32*(SETTLE_CYCLES+1) cycles from the START edge to the DONE edge.
- DONE:
  - BUSY=0, DONE=1, PASS=(ERR_CNT==0); stimulus outputs 0.
  - START=1: restart exactly as from IDLE, with DONE and PASS cleared on that edge.
- START while BUSY: ignored.
- ABORT:
  - In DRIVE, ABORT=1 at an edge returns to IDLE and forces stimulus outputs and BUSY to 0. DONE stays 0.
  - ERR_CNT, FAIL_VALID and FIRST_FAIL keep their partial values until the next START.
  - ABORT has priority over the compare on the same edge; that edge's sample is discarded.
  - ABORT in IDLE or DONE: no effect.
- Simultaneous START and ABORT in IDLE/DONE: START wins, and ABORT is evaluated from the next cycle.
- ERR_CNT width is 6 bits and its maximum is 32, so it never wraps.
- SETTLE_CYCLES=0: a compare happens every cycle, and ZN is sampled in the same cycle the vector first appears. This setting is intended only for a zero-delay gate model.

Test Plan:
- Good OAI221 model, SETTLE_CYCLES=2, START pulse -> BUSY high for 96 cycles, stimulus counts 0..31 with each vector held 3 cycles, then DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN tied to 1 -> DONE after 96 cycles, ERR_CNT=9, FIRST_FAIL=21 ({A,B1,B2,C1,C2}=10101), PASS=0.
- ZN tied to 0 -> ERR_CNT=23, FIRST_FAIL=0, FAIL_VALID=1, PASS=0.
- ABORT asserted at vector idx 10 -> next cycle BUSY=0, stimulus 0, DONE=0; a following START restarts at idx 0 with counters cleared.
- RST pulse at idx 20 -> all outputs 0 asynchronously; START held high during BUSY has no effect on the idx sequence.
- SETTLE_CYCLES=0 with zero-delay good model -> DONE 32 cycles after START, PASS=1; a second START from DONE repeats the sweep with identical results.

Source files
------------

// File: rtl/oai221_sweep_checker_if.sv
// Signal bundle between the OAI221 sweep checker and the gate under test.
// The checker drives the stimulus side (master); the gate/bench side is the slave.
interface oai221_sweep_checker_if;
    logic       start;
    logic       abort;
    logic       zn;
    logic       a;
    logic       b1;
    logic       b2;
    logic       c1;
    logic       c2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_cnt;
    logic       fail_valid;
    logic [4:0] first_fail;

    modport master (
        input  start, abort, zn,
        output a, b1, b2, c1, c2, busy, done, pass, err_cnt, fail_valid, first_fail
    );

    modport slave (
        output start, abort, zn,
        input  a, b1, b2, c1, c2, busy, done, pass, err_cnt, fail_valid, first_fail
    );
endinterface

// File: rtl/oai221_sweep_checker.sv
// Drives all 32 input vectors of an OAI221 instance, holds each for a settle
// period, samples ZN at the end of it and tallies mismatches against EXPECT.
module oai221_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [31:0] EXPECT        = 32'h111F_FFFF
) (
    input logic clk,
    input logic rst,
    oai221_sweep_checker_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [4:0] idx;
    logic [3:0] cnt;
    logic [4:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_cnt;
    logic       fail_valid;
    logic [4:0] first_fail;

    logic       mismatch;
    logic       at_sample;

    assign mismatch  = (bus.zn != EXPECT[idx]);
    assign at_sample = (cnt == SETTLE_LIM);

    // stim is always loaded with the idx value being entered, so at a compare
    // edge the vector on the pins is the one whose expectation is checked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 5'd0;
            cnt        <= 4'd0;
            stim       <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 6'd0;
            fail_valid <= 1'b0;
            first_fail <= 5'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state      <= S_DRIVE;
                        idx        <= 5'd0;
                        cnt        <= 4'd0;
                        stim       <= 5'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= 6'd0;
                        fail_valid <= 1'b0;
                        first_fail <= 5'd0;
                    end
                end
                S_DRIVE: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                        stim  <= 5'd0;
                        busy  <= 1'b0;
                    end else if (!at_sample) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + 6'd1;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= idx;
                            end
                        end
                        if (idx == 5'd31) begin
                            state <= S_DONE;
                            stim  <= 5'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == 6'd0) && !mismatch;
                        end else begin
                            idx  <= idx + 5'd1;
                            stim <= idx + 5'd1;
                            cnt  <= 4'd0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign {bus.a, bus.b1, bus.b2, bus.c1, bus.c2} = stim;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_cnt    = err_cnt;
    assign bus.fail_valid = fail_valid;
    assign bus.first_fail = first_fail;

endmodule
